// File: rtl/instr_seq_fsm_if.sv
// rtl/instr_seq_fsm_if.sv - instruction handshake and datapath control bundle for instr_seq_fsm
interface instr_seq_fsm_if;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  nsel;
  logic [1:0]  vsel;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;

  modport master (
    output s, in,
    input  w, nsel, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, ALUop, shift, sximm8
  );

  modport slave (
    input  s, in,
    output w, nsel, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, ALUop, shift, sximm8
  );
endinterface

// File: rtl/instr_seq_fsm.sv
// rtl/instr_seq_fsm.sv - multi-cycle sequencer stepping the register-file/shifter/ALU datapath
module instr_seq_fsm (
  input  logic            clk,
  input  logic            reset,
  instr_seq_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT, DECODE, WRITE_IMM, GET_A, GET_B, CALC, WRITE_REG
  } state_t;

  state_t state, state_next;

  // Register numbers reach the datapath only through nsel, so ir[10:8] is never needed;
  // Rd/Rm are kept anyway as part of imm8.
  logic [4:0] ir_ctl;   // opcode[15:13], op[12:11]
  logic [1:0] ir_sh;    // ir[4:3]
  logic [7:0] ir_imm;   // ir[7:0]

  logic [2:0] opcode;
  logic [1:0] op;
  logic is_mov_imm, is_mov_reg, is_alu3, is_cmp, is_mvn;

  assign opcode     = ir_ctl[4:2];
  assign op         = ir_ctl[1:0];
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_alu3    = (opcode == 3'b101) && (op != 2'b11);

  assign bus.sximm8 = {{8{ir_imm[7]}}, ir_imm};

  always_comb begin
    state_next = state;
    case (state)
      WAIT:      if (bus.s) state_next = DECODE;
      DECODE: begin
        if (is_mov_imm)                 state_next = WRITE_IMM;
        else if (is_alu3)               state_next = GET_A;
        else if (is_mov_reg || is_mvn)  state_next = GET_B;
        else                            state_next = WAIT;
      end
      GET_A:     state_next = GET_B;
      GET_B:     state_next = CALC;
      CALC:      state_next = is_cmp ? WAIT : WRITE_REG;
      WRITE_IMM: state_next = WAIT;
      WRITE_REG: state_next = WAIT;
      default:   state_next = WAIT;
    endcase
  end

  // Outputs are registered from the successor state so they line up with it as Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT;
      ir_ctl    <= '0;
      ir_sh     <= '0;
      ir_imm    <= '0;
      bus.w     <= 1'b1;
      bus.nsel  <= 3'b000;
      bus.vsel  <= 2'b00;
      bus.write <= 1'b0;
      bus.loada <= 1'b0;
      bus.loadb <= 1'b0;
      bus.loadc <= 1'b0;
      bus.loads <= 1'b0;
      bus.asel  <= 1'b0;
      bus.bsel  <= 1'b0;
      bus.ALUop <= 2'b00;
      bus.shift <= 2'b00;
    end else begin
      state <= state_next;
      if (state == WAIT && bus.s) begin
        ir_ctl <= bus.in[15:11];
        ir_sh  <= bus.in[4:3];
        ir_imm <= bus.in[7:0];
      end

      bus.w     <= (state_next == WAIT);
      bus.nsel  <= 3'b000;
      bus.vsel  <= 2'b00;
      bus.write <= 1'b0;
      bus.loada <= 1'b0;
      bus.loadb <= 1'b0;
      bus.loadc <= 1'b0;
      bus.loads <= 1'b0;
      bus.asel  <= 1'b0;
      bus.bsel  <= 1'b0;
      bus.ALUop <= 2'b00;
      bus.shift <= 2'b00;

      case (state_next)
        WRITE_IMM: begin
          bus.nsel  <= 3'b100;
          bus.vsel  <= 2'b01;
          bus.write <= 1'b1;
        end
        GET_A: begin
          bus.nsel  <= 3'b100;
          bus.loada <= 1'b1;
        end
        GET_B: begin
          bus.nsel  <= 3'b001;
          bus.loadb <= 1'b1;
          bus.shift <= ir_sh;
        end
        CALC: begin
          bus.shift <= ir_sh;
          bus.ALUop <= is_mov_reg ? 2'b00 : op;
          bus.asel  <= is_mov_reg;
          bus.loadc <= !is_cmp;
          bus.loads <= is_cmp;
        end
        WRITE_REG: begin
          bus.nsel  <= 3'b010;
          bus.vsel  <= 2'b00;
          bus.write <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq_fsm.sv
// tb/tb_instr_seq_fsm.sv - directed self-checking bench for instr_seq_fsm
module tb_instr_seq_fsm;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  instr_seq_fsm_if bus ();

  instr_seq_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, ALUop, shift}
  function automatic logic [16:0] o(input logic w, input logic [2:0] nsel, input logic [1:0] vsel,
                                    input logic wr, input logic la, input logic lb, input logic lc,
                                    input logic ls, input logic as, input logic [1:0] alu,
                                    input logic [1:0] sh);
    return {w, nsel, vsel, wr, la, lb, lc, ls, as, 1'b0, alu, sh};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.w, bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb, bus.loadc,
            bus.loads, bus.asel, bus.bsel, bus.ALUop, bus.shift};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_imm(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (bus.sximm8 === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.sximm8, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [16:0] IDLE = 17'h10000;
  localparam logic [16:0] ZERO = 17'h00000;

  initial begin
    reset  = 1'b1;
    bus.s  = 1'b0;
    bus.in = 16'h0000;
    step(); step();
    chk("reset_outputs", obs(), IDLE);
    chk_imm("reset_sximm8", 16'h0000);
    reset = 1'b0;
    step();
    chk("idle_no_s", obs(), IDLE);

    // MOV R0,#7
    bus.in = 16'hD007; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    chk("movi_decode", obs(), ZERO);
    step();
    chk("movi_write", obs(), o(0, 3'b100, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    chk_imm("movi_sximm8_pos", 16'h0007);
    step();
    chk("movi_wait", obs(), IDLE);

    // MOV R0,#-7
    bus.in = 16'hD0F9; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    step();
    chk("movi_neg_write", obs(), o(0, 3'b100, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    chk_imm("movi_sximm8_neg", 16'hFFF9);
    step();
    chk("movi_neg_wait", obs(), IDLE);

    // ADD R2,R1,R0
    bus.in = 16'hA140; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    chk("add_decode", obs(), ZERO);
    step(); chk("add_get_a", obs(), o(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("add_get_b", obs(), o(0, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("add_calc",  obs(), o(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    step(); chk("add_wr",    obs(), o(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("add_wait",  obs(), IDLE);

    // CMP R1,R0
    bus.in = 16'hA900; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    step(); chk("cmp_get_a", obs(), o(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("cmp_get_b", obs(), o(0, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("cmp_calc",  obs(), o(0, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00));
    step(); chk("cmp_wait",  obs(), IDLE);

    // MVN R3,R1,LSL#1
    bus.in = 16'hB869; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    step(); chk("mvn_get_b", obs(), o(0, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01));
    step(); chk("mvn_calc",  obs(), o(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b11, 2'b01));
    step(); chk("mvn_wr",    obs(), o(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("mvn_wait",  obs(), IDLE);

    // MOV R4,R2
    bus.in = 16'hC082; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    step(); chk("movr_get_b", obs(), o(0, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("movr_calc",  obs(), o(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00));
    step(); chk("movr_wr",    obs(), o(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("movr_wait",  obs(), IDLE);

    // Illegal opcode
    bus.in = 16'hE000; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    chk("ill_decode", obs(), ZERO);
    step(); chk("ill_wait", obs(), IDLE);

    // s held high: w high for exactly one cycle between illegal instructions
    bus.s = 1'b1;
    step(); chk("hold_decode1", obs(), ZERO);
    step(); chk("hold_wait",    obs(), IDLE);
    step(); chk("hold_decode2", obs(), ZERO);
    bus.s = 1'b0;
    step(); chk("hold_end", obs(), IDLE);

    // Reset during CALC of ADD
    bus.in = 16'hA140; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    step(); step(); step();
    chk("rst_in_calc", obs(), o(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    reset = 1'b1;
    step(); chk("rst_to_wait", obs(), IDLE);
    chk_imm("rst_clears_ir", 16'h0000);
    reset = 1'b0;
    step(); chk("rst_no_write", obs(), IDLE);

    // in changes during GET_B; shift and sximm8 keep the latched instruction
    bus.in = 16'hA158; bus.s = 1'b1;
    step(); bus.s = 1'b0;
    step(); step();
    chk("chg_get_b", obs(), o(0, 3'b001, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b11));
    bus.in = 16'hD0FF; bus.s = 1'b1;
    step(); chk("chg_calc", obs(), o(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'b11));
    chk_imm("chg_sximm8", 16'h0058);
    bus.s = 1'b0;
    step(); chk("chg_wr",   obs(), o(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(); chk("chg_wait", obs(), IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
